muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers, for the execute stage beside the ALU. It runs MULT, MULTU, DIV and DIVU over multiple cycles, one bit per cycle. It also handles MTHI and MTLO writes and exposes HI and LO continuously for MFHI and MFLO. The core stalls on `busy` until `done` pulses. This generalises the fixed 32-bit mult/div pair to any width, with defined divide-by-zero and overflow results and a proper busy/done handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe, sampled at the rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- src_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- src_b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  one-cycle pulse; HI/LO are valid and updated in this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high, clk domain only):
  - hi=0, lo=0, busy=0, done=0, FSM=IDLE.
  - Reset asserted mid-operation aborts the op; HI/LO are zeroed and no `done` is produced.
- FSM states: IDLE, ITER, FIX.
- IDLE:
  - start with op 0–3 latches the operands and sign mode, then goes to ITER with counter=WIDTH and busy=1.
  - start with op 4 loads hi<=src_a at that edge; op 5 loads lo<=src_a. No busy, no done.
  - op 6/7 is ignored.
- ITER:
  - One iteration per clock; the counter decrements and the FSM goes to FIX once the counter reaches 0.
  - Exactly WIDTH cycles are spent in ITER.
- FIX:
  - Sign correction is applied and hi/lo are registered.
  - done=1 and busy=0 are registered at the same edge; the FSM returns to IDLE.
- Latency: start sampled at edge E0; done high, with new hi/lo visible, in the cycle after edge E(WIDTH+1). With WIDTH=32, done is high 34 cycles after the start edge, counting the E0 cycle as 1.
- `busy` is high for the cycles after E0 up to and including E(WIDTH+1)'s preceding cycle. It is never high in the same cycle as `done`.
- start while busy is ignored, including MTHI/MTLO. No queueing; the in-flight op is unaffected.
- start in the same cycle `done` is high is accepted normally as a new IDLE request.
- Signed ops (MULT, DIV):
  - Operate on magnitudes, using WIDTH-bit unsigned magnitudes so that |MIN| = 2^(WIDTH-1) is representable.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
- Multiply: the 2*WIDTH-bit product is split as {hi,lo}; a shift-add algorithm is used.
- Divide:
  - Restoring division, one quotient bit per iteration; lo=quotient, hi=remainder.
  - Divide by zero (both signs): lo = all ones, hi = src_a (unmodified dividend). Full latency still applies.
  - Signed MIN / -1: lo=MIN, hi=0; no exception.
- hi and lo change only at: an MTHI/MTLO edge in IDLE, the FIX edge, and reset.
- Operand inputs may change after E0 without affecting the result.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD (-3), b=5 -> done after 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high in the 33 preceding cycles.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then, back-to-back in the done cycle, DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0xCAFEF00D, then MTLO 0x0BADBEEF in consecutive cycles -> hi/lo updated one edge later, busy/done stay 0. Then start MULT and, while busy, issue MTLO 0x1 -> ignored; final lo equals the product's low word.
5. Start DIVU; assert reset for 1 cycle at iteration 10 -> hi=lo=0, busy=0, and no done pulse ever appears. Next MULTU 3*4 -> lo=12, hi=0.
6. WIDTH=8 build: MULT 0x80*0x80 -> hi=0x40, lo=0x00, done 10 cycles after start. DIV 0x81 (-127) / 0x10 -> lo=0xF9 (-7), hi=0xF1 (-15).

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The core is the master; the unit is the slave.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Each op runs one bit per cycle on magnitudes; signs are restored in FIX.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // MULT and DIV have op[0] clear; MULTU and DIVU have it set.
  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.src_a[WIDTH-1];
  assign b_neg     = signed_op & bus.src_b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag     = b_neg ? -bus.src_b : bus.src_b;

  // Shift-add step: acc holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: acc holds {remainder, dividend bits shifting into quotient}.
  // When the trial subtraction succeeds the true difference fits in WIDTH bits.
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= b_q);
  assign rem_diff = rem_sh[WIDTH-1:0] - b_q;
  assign div_next = {(div_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    a_raw_d    = a_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d   = bus.op[1];
              neg_d      = a_neg ^ b_neg;
              rem_neg_d  = a_neg;
              div_zero_d = (bus.src_b == '0);
              a_raw_d    = bus.src_a;
              b_d        = b_mag;
              acc_d      = {{WIDTH{1'b0}}, a_mag};
              cnt_d      = CNT_W'(WIDTH);
              state_d    = ITER;
            end
            3'd4:    hi_d = bus.src_a;
            3'd5:    lo_d = bus.src_a;
            default: ;
          endcase
        end
      end
      ITER: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div_zero_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = a_raw_q;
        end else begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      a_raw_q    <= a_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit and an 8-bit instance share one stimulus
// path, selected by dut_sel; expected results are hand-computed constants.
module tb_muldiv_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_r;
  logic        dut_sel;
  logic [2:0]  op_r;
  logic [31:0] src_a_r, src_b_r;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  assign bus32.start = start_r & ~dut_sel;
  assign bus32.op    = op_r;
  assign bus32.src_a = src_a_r;
  assign bus32.src_b = src_b_r;
  assign bus8.start  = start_r & dut_sel;
  assign bus8.op     = op_r;
  assign bus8.src_a  = src_a_r[7:0];
  assign bus8.src_b  = src_b_r[7:0];

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  logic        busy_s, done_s;
  logic [31:0] hi_s, lo_s;
  assign busy_s = dut_sel ? bus8.busy : bus32.busy;
  assign done_s = dut_sel ? bus8.done : bus32.done;
  assign hi_s   = dut_sel ? {24'd0, bus8.hi} : bus32.hi;
  assign lo_s   = dut_sel ? {24'd0, bus8.lo} : bus32.lo;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op, follow it to done, and check timing and results.
  // Returns in the done cycle so a following call issues back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject_mtlo);
    int w;
    int n;
    int busy_n;
    bit seen;
    w = dut_sel ? 8 : 32;
    start_r = 1'b1;
    op_r    = op;
    src_a_r = a;
    src_b_r = b;
    tick();
    start_r = 1'b0;
    op_r    = 3'd6;
    src_a_r = $urandom;
    src_b_r = $urandom;
    n = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      if (done_s) begin
        seen = 1'b1;
      end else begin
        if (busy_s) busy_n++;
        if (inject_mtlo && n == 5) begin
          start_r = 1'b1;
          op_r    = 3'd5;
          src_a_r = 32'h1;
        end
        tick();
        n++;
        if (inject_mtlo && n == 6) begin
          start_r = 1'b0;
          op_r    = 3'd6;
          check_eq({tag, " lo held while busy"}, lo_s, 32'h0BADBEEF);
        end
      end
    end
    check_eq({tag, " done seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency edges"}, n, w + 1);
    check_eq({tag, " busy cycles"}, busy_n, w + 1);
    check_eq({tag, " busy low in done"}, 32'(busy_s), 32'd0);
    check_eq({tag, " hi"}, hi_s, exp_hi);
    check_eq({tag, " lo"}, lo_s, exp_lo);
    $display("txn %s: op=%0d a=0x%0h b=0x%0h -> hi=0x%0h lo=0x%0h after %0d edges",
             tag, op, a, b, hi_s, lo_s, n);
  endtask

  // Start a DIVU, reset partway through, and confirm the op is abandoned.
  task automatic run_reset_abort();
    int dones;
    start_r = 1'b1;
    op_r    = 3'd3;
    src_a_r = 32'h12345678;
    src_b_r = 32'd7;
    tick();
    start_r = 1'b0;
    op_r    = 3'd6;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort hi", bus32.hi, 32'd0);
    check_eq("abort lo", bus32.lo, 32'd0);
    check_eq("abort busy", 32'(bus32.busy), 32'd0);
    check_eq("abort done", 32'(bus32.done), 32'd0);
    dones = 0;
    repeat (60) begin
      if (bus32.done) dones++;
      tick();
    end
    check_eq("abort no done", dones, 0);
    $display("txn reset_abort: DIVU aborted, hi=0x%0h lo=0x%0h", bus32.hi, bus32.lo);
  endtask

  initial begin
    reset   = 1'b1;
    start_r = 1'b0;
    dut_sel = 1'b0;
    op_r    = 3'd6;
    src_a_r = '0;
    src_b_r = '0;
    repeat (3) tick();
    check_eq("reset hi32", bus32.hi, 32'd0);
    check_eq("reset lo32", bus32.lo, 32'd0);
    check_eq("reset busy32", 32'(bus32.busy), 32'd0);
    check_eq("reset done32", 32'(bus32.done), 32'd0);
    check_eq("reset hi8", {24'd0, bus8.hi}, 32'd0);
    check_eq("reset lo8", {24'd0, bus8.lo}, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mult_m3x5",    3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("multu_max",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_by0",     3'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b0);
    run_op("div_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_100_7",   3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run_op("div_7_m2",     3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);

    // MTHI then MTLO on consecutive edges, issued from the done cycle.
    start_r = 1'b1;
    op_r    = 3'd4;
    src_a_r = 32'hCAFEF00D;
    tick();
    check_eq("mthi hi", bus32.hi, 32'hCAFEF00D);
    check_eq("mthi busy", 32'(bus32.busy), 32'd0);
    check_eq("mthi done", 32'(bus32.done), 32'd0);
    op_r    = 3'd5;
    src_a_r = 32'h0BADBEEF;
    tick();
    start_r = 1'b0;
    op_r    = 3'd6;
    check_eq("mtlo lo", bus32.lo, 32'h0BADBEEF);
    check_eq("mtlo hi kept", bus32.hi, 32'hCAFEF00D);
    check_eq("mtlo busy", 32'(bus32.busy), 32'd0);
    check_eq("mtlo done", 32'(bus32.done), 32'd0);
    $display("txn mthi_mtlo: hi=0x%0h lo=0x%0h", bus32.hi, bus32.lo);
    tick();

    run_op("mult_ign_mtlo", 3'd0, 32'h1234, 32'h10, 32'd0, 32'h12340, 1'b1);
    tick();

    run_reset_abort();
    run_op("multu_3x4",    3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    tick();

    dut_sel = 1'b1;
    tick();
    run_op("w8_mult_min",  3'd0, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0);
    run_op("w8_div_m127",  3'd2, 32'h81, 32'h10, 32'hF1, 32'hF9, 1'b0);
    run_op("w8_div_by0",   3'd2, 32'h85, 32'h00, 32'h85, 32'hFF, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
